risc_alu: RTL and testbench
===========================

Name: risc_alu

Overview:
- 32-bit integer ALU for the execute stage of the 32-bit RISC datapath.
- Takes two operands and a 4-bit operation code, and returns a registered result plus a zero flag one clock later.
- All 16 codes of the 4-bit opcode space are defined, so every combination is legal.

Parameters:
- WIDTH, 32, operand/result width; shift amount is taken from the low $clog2(WIDTH) bits of reg2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operands and alu_ctrl are valid this cycle.
- reg1  input  WIDTH  operand A.
- reg2  input  WIDTH  operand B; low 5 bits are also the shift amount.
- alu_ctrl  input  4  operation select.
- dreg  output  WIDTH  registered result.
- zero  output  1  registered flag; 1 when dreg == 0.
- out_valid  output  1  dreg/zero hold the result of an accepted operation.

Behaviour:
- Opcodes (A=reg1, B=reg2, sh=B[4:0]):
  - 0 AND; 1 OR; 2 ADD; 3 XOR.
  - 4 SLL A<<sh; 5 SRL logical A>>sh; 6 SUB A-B; 7 SLT signed (A<B ? 1 : 0).
  - 8 SRA arithmetic A>>>sh; 9 SLTU unsigned compare; 10 NAND; 11 XNOR.
  - 12 NOR; 13 PASS_A; 14 PASS_B; 15 LUI = {B[15:0],16'h0}.
- ADD/SUB wrap modulo 2^WIDTH; no trap on overflow.
- SLT/SLTU results are zero-extended to WIDTH.
- Latency 1:
  - A cycle with in_valid=1 and rst_n=1 loads dreg with the result, loads zero with (result==0), and sets out_valid=1 at the next edge.
  - A cycle with in_valid=0 leaves dreg and zero holding their previous values, and clears out_valid to 0.
- No backpressure. A new operation may be issued every cycle; back-to-back operations produce back-to-back results.
- Reset (rst_n=0 at an edge): dreg=0, zero=1, out_valid=0.
  - Reset wins over in_valid in the same cycle.
  - Reset asserted mid-stream discards the pending result.
- zero is derived from the registered result only, never from the unregistered inputs.
- Shift by 0 returns A unchanged. Shift amounts above 31 are impossible by construction because only 5 bits are used.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined, two extra outputs are present:
  - carry (1 bit): carry-out for ADD, NOT borrow for SUB, 0 otherwise.
  - overflow (1 bit): signed overflow for ADD/SUB, 0 otherwise.
  - Both are registered with dreg and follow the same latency, hold and reset rules; reset value is 0.
- When not defined, these ports and their logic are absent, and all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - the alu_op_e enum of the 16 opcodes;
  - ALU_W=32;
  - SHAMT_W=5.
- One combinational sub-module, alu_shifter, handles SLL/SRL/SRA (input A, sh and mode; output shifted value).
- Top-level risc_alu contains the opcode mux, the adder/subtractor, the compare logic and the output registers.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> dreg=0, zero=1, out_valid=0; release -> first result appears one cycle after the next accepted input.
- A=F0000000, B=0000FEDC, one opcode per cycle for all 16 opcodes -> 1-cycle latency with these results:
  - AND=00000000 (zero=1); OR=F000FEDC; ADD=F000FEDC; XOR=F000FEDC.
  - SLL(sh=28)=00000000; SRL=0000000F; SUB=EFFF0124; SLT=00000001.
  - SRA=FFFFFFFF; SLTU=00000000; NAND=FFFFFFFF; XNOR=0FFF0123.
  - NOR=0FFF0123; PASS_A=F0000000; PASS_B=0000FEDC; LUI=FEDC0000.
- Wrap: ADD A=FFFFFFFF, B=00000001 -> dreg=0, zero=1; with ALU_FLAGS_EN: carry=1, overflow=0.
- Signed overflow: ADD A=7FFFFFFF, B=1 -> dreg=80000000, zero=0; with ALU_FLAGS_EN: overflow=1.
- Hold: issue SUB 5-5 (dreg=0, zero=1), then 3 cycles with in_valid=0 and changing inputs -> dreg/zero unchanged, out_valid=0.
- Reset mid-stream: rst_n=0 in the same cycle as in_valid=1 ADD 1+1 -> next edge dreg=0, zero=1, out_valid=0; the result 2 never appears.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the risc_alu execute-stage ALU.
// Optional flag outputs of the top are enabled with the ALU_FLAGS_EN macro.
package alu_pkg;

    localparam int ALU_W   = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        OP_AND    = 4'd0,
        OP_OR     = 4'd1,
        OP_ADD    = 4'd2,
        OP_XOR    = 4'd3,
        OP_SLL    = 4'd4,
        OP_SRL    = 4'd5,
        OP_SUB    = 4'd6,
        OP_SLT    = 4'd7,
        OP_SRA    = 4'd8,
        OP_SLTU   = 4'd9,
        OP_NAND   = 4'd10,
        OP_XNOR   = 4'd11,
        OP_NOR    = 4'd12,
        OP_PASS_A = 4'd13,
        OP_PASS_B = 4'd14,
        OP_LUI    = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL / SRL / SRA.
// Used by risc_alu; not affected by ALU_FLAGS_EN.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [SH_W-1:0]  sh,
    input  shift_mode_e      mode,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        result = a << sh;
        case (mode)
            SH_RL:   result = a >> sh;
            SH_RA:   result = WIDTH'($signed(a) >>> sh);
            default: result = a << sh;
        endcase
    end

endmodule

// File: rtl/risc_alu.sv
// 32-bit execute-stage ALU with a one-cycle registered result and zero flag.
// Define ALU_FLAGS_EN to add registered carry and overflow outputs.
module risc_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic [3:0]       alu_ctrl,
`ifdef ALU_FLAGS_EN
    output logic             carry,
    output logic             overflow,
`endif
    output logic [WIDTH-1:0] dreg,
    output logic             zero,
    output logic             out_valid
);

    localparam int SH_W = $clog2(WIDTH);

    alu_op_e          op;
    shift_mode_e      sh_mode;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] add_sum;
    logic [WIDTH-1:0] sh_result;
    logic [WIDTH-1:0] result;

    assign op     = alu_op_e'(alu_ctrl);
    assign is_sub = (op == OP_SUB);
    // Subtraction reuses the adder as A + ~B + 1.
    assign b_eff  = is_sub ? ~reg2 : reg2;

`ifdef ALU_FLAGS_EN
    logic add_carry;
    logic add_ovf;
    logic is_arith;

    assign {add_carry, add_sum} = {1'b0, reg1} + {1'b0, b_eff} + (WIDTH+1)'(is_sub);
    assign add_ovf  = (reg1[WIDTH-1] == b_eff[WIDTH-1]) && (add_sum[WIDTH-1] != reg1[WIDTH-1]);
    assign is_arith = (op == OP_ADD) || is_sub;
`else
    assign add_sum = reg1 + b_eff + WIDTH'(is_sub);
`endif

    always_comb begin
        sh_mode = SH_LL;
        if (op == OP_SRL) sh_mode = SH_RL;
        if (op == OP_SRA) sh_mode = SH_RA;
    end

    alu_shifter #(.WIDTH(WIDTH), .SH_W(SH_W)) u_shifter (
        .a      (reg1),
        .sh     (reg2[SH_W-1:0]),
        .mode   (sh_mode),
        .result (sh_result)
    );

    always_comb begin
        result = '0;
        case (op)
            OP_AND:    result = reg1 & reg2;
            OP_OR:     result = reg1 | reg2;
            OP_ADD:    result = add_sum;
            OP_XOR:    result = reg1 ^ reg2;
            OP_SLL:    result = sh_result;
            OP_SRL:    result = sh_result;
            OP_SUB:    result = add_sum;
            OP_SLT:    result = WIDTH'($signed(reg1) < $signed(reg2));
            OP_SRA:    result = sh_result;
            OP_SLTU:   result = WIDTH'(reg1 < reg2);
            OP_NAND:   result = ~(reg1 & reg2);
            OP_XNOR:   result = ~(reg1 ^ reg2);
            OP_NOR:    result = ~(reg1 | reg2);
            OP_PASS_A: result = reg1;
            OP_PASS_B: result = reg2;
            OP_LUI:    result = reg2 << 16;
            default:   result = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dreg      <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
`ifdef ALU_FLAGS_EN
            carry     <= 1'b0;
            overflow  <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                dreg <= result;
                zero <= (result == '0);
`ifdef ALU_FLAGS_EN
                carry    <= is_arith & add_carry;
                overflow <= is_arith & add_ovf;
`endif
            end
        end
    end

endmodule

// File: tb/tb_risc_alu.sv
// Self-checking bench for risc_alu: opcode vector table plus reset/hold/wrap sequences.
// Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_risc_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [3:0]  alu_ctrl;
    logic [31:0] dreg;
    logic        zero;
    logic        out_valid;
`ifdef ALU_FLAGS_EN
    logic        carry;
    logic        overflow;
`endif

    int passed = 0;
    int total  = 0;

    risc_alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .reg1      (reg1),
        .reg2      (reg2),
        .alu_ctrl  (alu_ctrl),
`ifdef ALU_FLAGS_EN
        .carry     (carry),
        .overflow  (overflow),
`endif
        .dreg      (dreg),
        .zero      (zero),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        else
            passed++;
    endtask

    // Drive one accepted operation and step to 1 ns after the edge that captures it.
    task automatic issue(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        alu_ctrl = op;
        reg1     = a;
        reg2     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctrl);
        in_valid = 1'b0;
        alu_ctrl = ctrl;
        reg1     = a;
        reg2     = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{OP_AND,    32'hF000_0000, 32'h0000_FEDC, 32'h0000_0000, 1'b1};
        vecs[1]  = '{OP_OR,     32'hF000_0000, 32'h0000_FEDC, 32'hF000_FEDC, 1'b0};
        vecs[2]  = '{OP_ADD,    32'hF000_0000, 32'h0000_FEDC, 32'hF000_FEDC, 1'b0};
        vecs[3]  = '{OP_XOR,    32'hF000_0000, 32'h0000_FEDC, 32'hF000_FEDC, 1'b0};
        vecs[4]  = '{OP_SLL,    32'hF000_0000, 32'h0000_FEDC, 32'h0000_0000, 1'b1};
        vecs[5]  = '{OP_SRL,    32'hF000_0000, 32'h0000_FEDC, 32'h0000_000F, 1'b0};
        vecs[6]  = '{OP_SUB,    32'hF000_0000, 32'h0000_FEDC, 32'hEFFF_0124, 1'b0};
        vecs[7]  = '{OP_SLT,    32'hF000_0000, 32'h0000_FEDC, 32'h0000_0001, 1'b0};
        vecs[8]  = '{OP_SRA,    32'hF000_0000, 32'h0000_FEDC, 32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{OP_SLTU,   32'hF000_0000, 32'h0000_FEDC, 32'h0000_0000, 1'b1};
        vecs[10] = '{OP_NAND,   32'hF000_0000, 32'h0000_FEDC, 32'hFFFF_FFFF, 1'b0};
        vecs[11] = '{OP_XNOR,   32'hF000_0000, 32'h0000_FEDC, 32'h0FFF_0123, 1'b0};
        vecs[12] = '{OP_NOR,    32'hF000_0000, 32'h0000_FEDC, 32'h0FFF_0123, 1'b0};
        vecs[13] = '{OP_PASS_A, 32'hF000_0000, 32'h0000_FEDC, 32'hF000_0000, 1'b0};
        vecs[14] = '{OP_PASS_B, 32'hF000_0000, 32'h0000_FEDC, 32'h0000_FEDC, 1'b0};
        vecs[15] = '{OP_LUI,    32'hF000_0000, 32'h0000_FEDC, 32'hFEDC_0000, 1'b0};

        // Reset held two cycles while in_valid is asserted.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        alu_ctrl = OP_ADD;
        reg1     = 32'd1;
        reg2     = 32'd1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dreg", dreg, 32'h0);
        check("reset_zero", 32'(zero), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
`ifdef ALU_FLAGS_EN
        check("reset_carry", 32'(carry), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
`endif

        rst_n = 1'b1;
        idle(32'h1234_5678, 32'h1, 4'd2);
        check("release_idle_out_valid", 32'(out_valid), 32'd0);
        check("release_idle_dreg", dreg, 32'h0);

        // All 16 opcodes issued back to back.
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("op%0d_dreg", i), dreg, vecs[i].exp);
            check($sformatf("op%0d_zero", i), 32'(zero), 32'(vecs[i].exp_zero));
            check($sformatf("op%0d_out_valid", i), 32'(out_valid), 32'd1);
        end

        // Shift by zero leaves A unchanged.
        issue(OP_SRA, 32'h8000_0001, 32'hFFFF_FFE0);
        check("sra_sh0", dreg, 32'h8000_0001);
        issue(OP_SLL, 32'h0000_0001, 32'h0000_001F);
        check("sll_sh31", dreg, 32'h8000_0000);

        // Wraparound add.
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        check("wrap_dreg", dreg, 32'h0);
        check("wrap_zero", 32'(zero), 32'd1);
`ifdef ALU_FLAGS_EN
        check("wrap_carry", 32'(carry), 32'd1);
        check("wrap_overflow", 32'(overflow), 32'd0);
`endif

        // Signed overflow.
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        check("ovf_dreg", dreg, 32'h8000_0000);
        check("ovf_zero", 32'(zero), 32'd0);
`ifdef ALU_FLAGS_EN
        check("ovf_overflow", 32'(overflow), 32'd1);
        check("ovf_carry", 32'(carry), 32'd0);
        issue(OP_SUB, 32'h0000_0003, 32'h0000_0005);
        check("sub_borrow_carry", 32'(carry), 32'd0);
        issue(OP_XOR, 32'hFFFF_FFFF, 32'h0000_0001);
        check("logic_carry_clear", 32'(carry), 32'd0);
`endif

        // Hold: result stays while in_valid is low.
        issue(OP_SUB, 32'd5, 32'd5);
        check("hold_sub_dreg", dreg, 32'h0);
        check("hold_sub_zero", 32'(zero), 32'd1);
        for (int i = 0; i < 3; i++) begin
            idle(32'h1111_0000 + 32'(i), 32'h0000_0F0F << i, 4'(i + 1));
            check($sformatf("hold%0d_dreg", i), dreg, 32'h0);
            check($sformatf("hold%0d_zero", i), 32'(zero), 32'd1);
            check($sformatf("hold%0d_out_valid", i), 32'(out_valid), 32'd0);
        end

        // Reset mid-stream beats a valid ADD 1+1.
        issue(OP_ADD, 32'd7, 32'd1);
        check("pre_reset_dreg", dreg, 32'd8);
        rst_n = 1'b0;
        issue(OP_ADD, 32'd1, 32'd1);
        check("midreset_dreg", dreg, 32'h0);
        check("midreset_zero", 32'(zero), 32'd1);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        idle(32'd1, 32'd1, 4'd2);
        check("post_reset_dreg", dreg, 32'h0);
        check("post_reset_out_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
